// File: rtl/fetch_unit.sv
// Fetch stage: PC, in-order imem requests, response FIFO to decode.
// Handles branch redirect (flush + drop of in-flight words) and sticky halt.
module fetch_unit #(
  parameter int                     WIDTH    = 32,
  parameter int                     PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
  parameter int                     DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [WIDTH-1:0]    imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WIDTH-1:0]    inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt_req,
  output logic                halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CW-1:0]       r_out;
  logic [CW-1:0]       r_drop;
  logic [CW-1:0]       r_cnt;
  logic [AW-1:0]       r_rp;
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_qr;
  logic [AW-1:0]       r_qw;
  logic [WIDTH-1:0]    r_fd [DEPTH];
  logic [PC_WIDTH-1:0] r_fp [DEPTH];
  logic [PC_WIDTH-1:0] r_pq [DEPTH];

  logic w_run;
  logic w_room;
  logic w_pop;
  logic w_halt;
  logic w_redir;
  logic w_req;
  logic w_resp;
  logic w_push;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Room counts both in-flight words and buffered ones
  assign w_run   = (r_state == S_RUN);
  assign w_room  = ({1'b0, r_out} + {1'b0, r_cnt}) < (CW+1)'(DEPTH);
  assign w_pop   = inst_valid && inst_ready;
  assign w_halt  = halt_req && w_pop;
  assign w_redir = redirect_valid && w_run && !w_halt;
  assign w_req   = imem_req_valid && imem_req_ready;
  assign w_resp  = imem_resp_valid && (r_out != '0);
  assign w_push  = w_resp && (r_drop == '0) && w_run;

  assign imem_req_valid = rst_n && w_run && w_room && !redirect_valid
                        && !(halt_req && inst_valid);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_cnt != '0) && w_run;
  assign inst           = r_fd[r_rp];
  assign inst_pc        = r_fp[r_rp];
  assign halted         = (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_drop  <= '0;
      r_qr    <= '0;
      r_qw    <= '0;
      for (int i = 0; i < DEPTH; i++) r_pq[i] <= '0;
    end else begin
      if (w_halt) r_state <= S_HALT;
      if (w_redir) r_pc <= redirect_pc;
      else if (w_req) r_pc <= r_pc + PC_WIDTH'(1);
      r_out <= r_out + CW'(w_req) - CW'(w_resp);
      // Everything still in flight after this edge is stale
      if (w_redir) r_drop <= r_out - CW'(w_resp);
      else if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      if (w_req) begin
        r_pq[r_qw] <= r_pc;
        r_qw       <= nxt(r_qw);
      end
      if (w_resp) r_qr <= nxt(r_qr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rp  <= '0;
      r_wp  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fd[i] <= '0;
        r_fp[i] <= '0;
      end
    end else if (w_halt || w_redir) begin
      r_cnt <= '0;
      r_rp  <= '0;
      r_wp  <= '0;
    end else begin
      if (w_push) begin
        r_fd[r_wp] <= imem_resp_data;
        r_fp[r_wp] <= r_pq[r_qr];
        r_wp       <= nxt(r_wp);
      end
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a program-order
// reference of expected request and delivery PCs.
module tb_fetch_unit;
  localparam int          W   = 32;
  localparam int          PW  = 16;
  localparam int          D   = 2;
  localparam logic [15:0] RPC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [PW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [W-1:0]  imem_resp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [W-1:0]  inst;
  logic [PW-1:0] inst_pc;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          halt_req;
  logic          halted;

  fetch_unit #(
    .WIDTH(W), .PC_WIDTH(PW), .RESET_PC(RPC), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc, lat_lo, lat_hi;
  int          p_rdy, p_ird, p_redir;
  int          halt_at;
  bit          halt_redir;
  bit          force_redir;
  logic [15:0] force_pc;
  logic [15:0] m_req, m_dec;
  bit          m_halt;
  int          n_acc, n_del, first_del;
  logic [15:0] first_req, first_pc;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [31:0] memw(logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset(bit check);
    rst_n = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = '0; halt_req = 0;
    pend.delete();
    m_req = RPC; m_dec = RPC; m_halt = 0;
    n_acc = 0; n_del = 0; first_del = -1; cyc = 0;
    halt_at = -1; halt_redir = 0; force_redir = 0;
    #1;
    if (check) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle();
    req_t r;
    cyc++;
    imem_resp_valid = 0;
    imem_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_resp_valid = 1;
      imem_resp_data  = memw(r.a);
    end
    imem_req_ready = ($urandom_range(99) < p_rdy);
    inst_ready     = ($urandom_range(99) < p_ird);
    redirect_valid = ($urandom_range(999) < p_redir);
    redirect_pc    = 16'($urandom);
    halt_req       = 0;
    if (force_redir) begin
      redirect_valid = 1;
      redirect_pc    = force_pc;
    end
    if (halt_at >= 0 && inst_valid && inst_pc == 16'(halt_at)) begin
      halt_req = 1;
      if (halt_redir) begin
        redirect_valid = 1;
        redirect_pc    = 16'h0080;
      end
    end
    #1;
    chk("halted", halted, m_halt);
    if (m_halt) begin
      chk("halt_no_req", imem_req_valid, 0);
      chk("halt_no_inst", inst_valid, 0);
    end
    if (redirect_valid) chk("redir_no_req", imem_req_valid, 0);
    if (halt_req && inst_valid) chk("halt_cyc_no_req", imem_req_valid, 0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, m_req);
      if (n_acc == 0) first_req = imem_req_addr;
      m_req++;
      n_acc++;
      r.a   = imem_req_addr;
      r.due = cyc + $urandom_range(lat_hi, lat_lo);
      pend.push_back(r);
      chk("outstanding_bound", pend.size() <= D, 1);
    end
    if (inst_valid && inst_ready) begin
      if (n_del == 0) begin
        first_del = cyc;
        first_pc  = inst_pc;
      end
      chk("inst_pc", inst_pc, m_dec);
      chk("inst", inst, memw(m_dec));
      n_del++;
      if (halt_req) m_halt = 1;
      m_dec++;
    end
    if (redirect_valid && !m_halt) begin
      m_req = redirect_pc;
      m_dec = redirect_pc;
    end
    @(negedge clk);
  endtask

  initial begin
    p_redir = 0;
    @(negedge clk);

    // straight line, latency 1
    lat_lo = 1; lat_hi = 1; p_rdy = 100; p_ird = 100;
    do_reset(1);
    repeat (30) cycle();
    chk("first_valid_cycle", first_del, 3);
    chk("throughput", n_del >= 16, 1);

    // decode backpressure
    do_reset(0);
    p_ird = 0;
    repeat (8) cycle();
    chk("bp_reqs", n_acc, 2);
    chk("bp_stall", imem_req_valid, 0);
    p_ird = 100;
    repeat (12) cycle();
    chk("bp_resume", n_del >= 4, 1);

    // redirect with two in flight
    do_reset(0);
    lat_lo = 3; lat_hi = 3;
    cycle();
    cycle();
    force_redir = 1; force_pc = 16'h0040;
    cycle();
    force_redir = 0;
    n_acc = 0; n_del = 0;
    repeat (12) cycle();
    chk("redir_first_req", first_req, 16'h0040);
    chk("redir_first_pc", first_pc, 16'h0040);

    // halt at pc 3 with late responses
    do_reset(0);
    lat_lo = 2; lat_hi = 2;
    halt_at = 3;
    repeat (20) cycle();
    chk("halt_delivered", n_del, 4);
    chk("halt_sticky", halted, 1);

    // halt and redirect together
    do_reset(0);
    lat_lo = 1; lat_hi = 1;
    halt_at = 2; halt_redir = 1;
    repeat (15) cycle();
    chk("hr_delivered", n_del, 3);
    chk("hr_halted", halted, 1);

    // async reset mid-stream with two outstanding
    do_reset(0);
    lat_lo = 3; lat_hi = 3; p_ird = 0;
    cycle();
    cycle();
    chk("pre_rst_full", imem_req_valid, 0);
    #2;
    do_reset(1);
    lat_lo = 1; lat_hi = 1; p_ird = 100;
    repeat (10) cycle();
    chk("post_rst_first_req", first_req, RPC);
    chk("post_rst_first_pc", first_pc, RPC);

    // random traffic with redirects
    do_reset(0);
    lat_lo = 1; lat_hi = 4; p_rdy = 70; p_ird = 60; p_redir = 30;
    repeat (3000) cycle();
    chk("rand_progress", n_del > 100, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
